// File: rtl/vga_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module   : vga_rect_fill
//  Purpose  : Fills a clipped rectangle of pixel pairs in the 640x480x16
//             framebuffer through the controller's byte-wide memory port.
//  Revision : 1.0
// ============================================================================

module vga_rect_fill #(
    parameter int unsigned VMEM_START  = 0,
    parameter logic [25:0] PARK_ADDR   = 26'h3FFFFFF,
    parameter int unsigned LINE_BYTES  = 512,
    parameter int unsigned LINE_OFFSET = 4
) (
    input  logic        clock_100_mhz,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [8:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic [8:0]  cmd_w,
    input  logic [8:0]  cmd_h,
    input  logic [3:0]  cmd_color,
    output logic        done,
    output logic [25:0] mem_address,
    output logic        mem_we,
    output logic [7:0]  mem_data,
    input  logic        mem_ready
);

    localparam logic [25:0] c_base_addr  = 26'(2 * VMEM_START + LINE_OFFSET);
    localparam logic [25:0] c_line_bytes = 26'(LINE_BYTES);
    localparam logic [9:0]  c_x_limit    = 10'd320;
    localparam logic [9:0]  c_y_limit    = 10'd480;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_PARK      = 3'd2,
        S_ISSUE     = 3'd3,
        S_ACK       = 3'd4,
        S_DONE_WAIT = 3'd5,
        S_NEXT      = 3'd6,
        S_FINISH    = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  x_start_q, x_start_d;
    logic [9:0]  col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic [9:0]  x_end_q, x_end_d;
    logic [9:0]  y_end_q, y_end_d;
    logic [3:0]  color_q, color_d;
    logic        empty_q, empty_d;
    logic        park_q, park_d;
    logic [25:0] mem_address_q, mem_address_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_data_q, mem_data_d;

    logic [9:0]  w_x_sum;
    logic [9:0]  w_y_sum;
    logic [9:0]  w_x_end;
    logic [9:0]  w_y_end;
    logic        w_empty;
    logic [9:0]  w_col_inc;
    logic [9:0]  w_row_inc;
    logic [25:0] w_target;

    // Clipping is done in 10 bits so x+w / y+h cannot overflow.
    assign w_x_sum   = {1'b0, cmd_x} + {1'b0, cmd_w};
    assign w_y_sum   = {1'b0, cmd_y} + {1'b0, cmd_h};
    assign w_x_end   = (w_x_sum > c_x_limit) ? c_x_limit : w_x_sum;
    assign w_y_end   = (w_y_sum > c_y_limit) ? c_y_limit : w_y_sum;
    assign w_empty   = (cmd_w == 9'd0) || (cmd_h == 9'd0) ||
                       ({1'b0, cmd_x} >= c_x_limit) || ({1'b0, cmd_y} >= c_y_limit);
    assign w_col_inc = col_q + 10'd1;
    assign w_row_inc = row_q + 10'd1;
    assign w_target  = c_base_addr + (26'(row_q) * c_line_bytes) + 26'(col_q);

    assign mem_address = mem_address_q;
    assign mem_we      = mem_we_q;
    assign mem_data    = mem_data_q;

    always_ff @(posedge clock_100_mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            x_start_q     <= '0;
            col_q         <= '0;
            row_q         <= '0;
            x_end_q       <= '0;
            y_end_q       <= '0;
            color_q       <= '0;
            empty_q       <= 1'b0;
            park_q        <= 1'b0;
            mem_address_q <= '0;
            mem_we_q      <= 1'b0;
            mem_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            x_start_q     <= x_start_d;
            col_q         <= col_d;
            row_q         <= row_d;
            x_end_q       <= x_end_d;
            y_end_q       <= y_end_d;
            color_q       <= color_d;
            empty_q       <= empty_d;
            park_q        <= park_d;
            mem_address_q <= mem_address_d;
            mem_we_q      <= mem_we_d;
            mem_data_q    <= mem_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        x_start_d     = x_start_q;
        col_d         = col_q;
        row_d         = row_q;
        x_end_d       = x_end_q;
        y_end_d       = y_end_q;
        color_d       = color_q;
        empty_d       = empty_q;
        park_d        = park_q;
        mem_address_d = mem_address_q;
        mem_we_d      = mem_we_q;
        mem_data_d    = mem_data_q;
        cmd_ready     = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    x_start_d = {1'b0, cmd_x};
                    col_d     = {1'b0, cmd_x};
                    row_d     = {1'b0, cmd_y};
                    x_end_d   = w_x_end;
                    y_end_d   = w_y_end;
                    color_d   = cmd_color;
                    empty_d   = w_empty;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                // The controller only starts on an address change, so a first
                // target equal to the held address needs a dummy read first.
                if (empty_q) begin
                    state_d = S_FINISH;
                end else if (w_target == mem_address_q) begin
                    state_d = S_PARK;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_PARK: begin
                mem_address_d = PARK_ADDR;
                mem_we_d      = 1'b0;
                park_d        = 1'b1;
                state_d       = S_ACK;
            end
            S_ISSUE: begin
                mem_address_d = w_target;
                mem_we_d      = 1'b1;
                mem_data_d    = {color_q, color_q};
                park_d        = 1'b0;
                state_d       = S_ACK;
            end
            S_ACK: begin
                if (!mem_ready) begin
                    state_d = S_DONE_WAIT;
                end
            end
            S_DONE_WAIT: begin
                if (mem_ready) begin
                    state_d = park_q ? S_ISSUE : S_NEXT;
                end
            end
            S_NEXT: begin
                if (w_col_inc >= x_end_q) begin
                    if (w_row_inc >= y_end_q) begin
                        state_d = S_FINISH;
                    end else begin
                        col_d   = x_start_q;
                        row_d   = w_row_inc;
                        state_d = S_ISSUE;
                    end
                end else begin
                    col_d   = w_col_inc;
                    state_d = S_ISSUE;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_rect_fill
//  Purpose  : Directed self-checking bench for vga_rect_fill with a simple
//             controller responder that logs every memory transaction.
//  Revision : 1.0
// ============================================================================

module tb_vga_rect_fill;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [8:0]  cmd_w;
    logic [8:0]  cmd_h;
    logic [3:0]  cmd_color;
    logic        done;
    logic [25:0] mem_address;
    logic        mem_we;
    logic [7:0]  mem_data;
    logic        mem_ready;

    int n_assert = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int cyc      = 0;
    int hi_cfg   = 0;
    int lo_cfg   = 1;

    logic [25:0] t_addr[$];
    logic        t_we[$];
    logic [7:0]  t_data[$];
    int          t_cyc[$];

    vga_rect_fill dut (
        .clock_100_mhz (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_x         (cmd_x),
        .cmd_y         (cmd_y),
        .cmd_w         (cmd_w),
        .cmd_h         (cmd_h),
        .cmd_color     (cmd_color),
        .done          (done),
        .mem_address   (mem_address),
        .mem_we        (mem_we),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Controller stand-in: a new address starts a transaction; ready stays
    // high for hi_cfg cycles, low for lo_cfg cycles, then returns high.
    initial begin
        logic [25:0] prev;
        int hi_left;
        int lo_left;
        prev      = '0;
        hi_left   = 0;
        lo_left   = 0;
        mem_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                mem_ready = 1'b1;
                prev      = mem_address;
                hi_left   = 0;
                lo_left   = 0;
            end else begin
                if (done) n_done++;
                if (mem_address !== prev) begin
                    prev = mem_address;
                    t_addr.push_back(mem_address);
                    t_we.push_back(mem_we);
                    t_data.push_back(mem_data);
                    t_cyc.push_back(cyc);
                    hi_left = hi_cfg;
                    lo_left = lo_cfg;
                end
                if (hi_left > 0) begin
                    hi_left--;
                    mem_ready = 1'b1;
                end else if (lo_left > 0) begin
                    lo_left--;
                    mem_ready = 1'b0;
                end else begin
                    mem_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_txn(input string tag, input int idx, input logic [25:0] a,
                           input logic we, input logic [7:0] d, input bit chk_data);
        if (idx >= t_addr.size()) begin
            chk({tag, "_present"}, 32'(t_addr.size()), 32'(idx + 1));
        end else begin
            chk({tag, "_addr"}, 32'(t_addr[idx]), 32'(a));
            chk({tag, "_we"},   32'(t_we[idx]),   32'(we));
            if (chk_data) chk({tag, "_data"}, 32'(t_data[idx]), 32'(d));
        end
    endtask

    task automatic run_cmd(input logic [8:0] x, input logic [8:0] y, input logic [8:0] w,
                           input logic [8:0] h, input logic [3:0] c, input bit poke);
        int k;
        bit seen;
        k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        if (poke) begin
            cmd_x = 9'd0; cmd_y = 9'd0; cmd_w = 9'd1; cmd_h = 9'd1; cmd_color = 4'hF;
            repeat (3) @(negedge clk);
        end
        cmd_valid = 1'b0;
        k = 0;
        seen = 1'b0;
        while (k < 3000 && !seen) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("cmd_done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int base;
        int d0;
        int k;
        reset_n = 1'b0; cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_addr",      32'(mem_address), 32'd0);
        chk("rst_we",        32'(mem_we),    32'd0);
        chk("rst_data",      32'(mem_data),  32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1x1 at (0,0): first target is 4, held address is 0 -> direct write
        base = t_addr.size(); d0 = n_done;
        run_cmd(9'd0, 9'd0, 9'd1, 9'd1, 4'h5, 1'b0);
        repeat (3) @(negedge clk);
        chk("t1_ntx", 32'(t_addr.size() - base), 32'd1);
        chk_txn("t1_wr", base, 26'd4, 1'b1, 8'h55, 1'b1);
        chk("t1_done_cnt", 32'(n_done - d0), 32'd1);

        // 2x2 at (10,3) with cmd_valid held during the busy period
        base = t_addr.size(); d0 = n_done;
        run_cmd(9'd10, 9'd3, 9'd2, 9'd2, 4'hA, 1'b1);
        repeat (3) @(negedge clk);
        chk("t2_ntx", 32'(t_addr.size() - base), 32'd4);
        chk_txn("t2_w0", base,     26'd1550, 1'b1, 8'hAA, 1'b1);
        chk_txn("t2_w1", base + 1, 26'd1551, 1'b1, 8'hAA, 1'b1);
        chk_txn("t2_w2", base + 2, 26'd2062, 1'b1, 8'hAA, 1'b1);
        chk_txn("t2_w3", base + 3, 26'd2063, 1'b1, 8'hAA, 1'b1);
        if (t_cyc.size() >= base + 2)
            chk("t2_min_gap", 32'(t_cyc[base + 1] - t_cyc[base]), 32'd4);
        chk("t2_done_cnt", 32'(n_done - d0), 32'd1);

        // 1x1 at (11,4) targets 2063, the held address -> park read first
        base = t_addr.size();
        run_cmd(9'd11, 9'd4, 9'd1, 9'd1, 4'h3, 1'b0);
        repeat (3) @(negedge clk);
        chk("t3_ntx", 32'(t_addr.size() - base), 32'd2);
        chk_txn("t3_park", base,     26'h3FFFFFF, 1'b0, 8'h00, 1'b0);
        chk_txn("t3_wr",   base + 1, 26'd2063,    1'b1, 8'h33, 1'b1);

        // Clip at the bottom-right corner
        base = t_addr.size();
        run_cmd(9'd318, 9'd479, 9'd5, 9'd4, 4'h7, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_ntx", 32'(t_addr.size() - base), 32'd2);
        chk_txn("t4_w0", base,     26'd245570, 1'b1, 8'h77, 1'b1);
        chk_txn("t4_w1", base + 1, 26'd245571, 1'b1, 8'h77, 1'b1);

        // Zero width: cycle-exact done / cmd_ready timing, no transaction
        base = t_addr.size();
        cmd_x = 9'd5; cmd_y = 9'd5; cmd_w = 9'd0; cmd_h = 9'd3; cmd_color = 4'h2;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t5_c0_ready", 32'(cmd_ready), 32'd0);
        chk("t5_c0_done",  32'(done),      32'd0);
        @(negedge clk);
        chk("t5_c1_done",  32'(done),      32'd1);
        chk("t5_c1_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("t5_c2_done",  32'(done),      32'd0);
        chk("t5_c2_ready", 32'(cmd_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("t5_ntx",  32'(t_addr.size() - base), 32'd0);
        chk("t5_addr", 32'(mem_address), 32'd245571);

        // Slow controller: ready high 3 cycles after issue, low 20, then high
        hi_cfg = 3; lo_cfg = 20;
        base = t_addr.size();
        run_cmd(9'd100, 9'd10, 9'd2, 9'd1, 4'h1, 1'b0);
        repeat (3) @(negedge clk);
        hi_cfg = 0; lo_cfg = 1;
        chk("t6_ntx", 32'(t_addr.size() - base), 32'd2);
        chk_txn("t6_w0", base,     26'd5224, 1'b1, 8'h11, 1'b1);
        chk_txn("t6_w1", base + 1, 26'd5225, 1'b1, 8'h11, 1'b1);
        if (t_cyc.size() >= base + 2)
            chk("t6_gap", 32'(t_cyc[base + 1] - t_cyc[base]), 32'd26);

        // Reset in the middle of a 4x2 rectangle
        base = t_addr.size();
        cmd_x = 9'd0; cmd_y = 9'd20; cmd_w = 9'd4; cmd_h = 9'd2; cmd_color = 4'h9;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (t_addr.size() < base + 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t7_started", 32'(t_addr.size() - base), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("t7_rst_ready", 32'(cmd_ready),   32'd1);
        chk("t7_rst_done",  32'(done),        32'd0);
        chk("t7_rst_addr",  32'(mem_address), 32'd0);
        chk("t7_rst_we",    32'(mem_we),      32'd0);
        chk("t7_rst_data",  32'(mem_data),    32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t7_no_new_tx", 32'(t_addr.size() - base), 32'd2);
        chk("t7_addr_idle", 32'(mem_address), 32'd0);
        chk("t7_ready",     32'(cmd_ready),   32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
